ahb_master: RTL and testbench

//  AHB-lite master (initiator) bridging the SCSU core's simple request/ack port onto the 16-bit scsu_m_ahb_* bus.

---
 rtl/ahb_master_if.sv | 38 +++
 rtl/ahb_master.sv | 121 ++++++++++++
 tb/tb_ahb_master.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_if.sv
// Core request/ack port plus 16-bit AHB-lite bus seen by the SCSU AHB master.
// The master modport is the initiator's view; the slave modport is the core/bus side.
interface ahb_master_if;
    logic        core_req;
    logic        core_wr;
    logic [1:0]  core_size;
    logic [15:0] core_addr;
    logic [15:0] core_wdata;
    logic        core_ack;
    logic        core_done;
    logic        core_err;
    logic [15:0] core_rdata;

    logic [1:0]  scsu_m_ahb_mhtrans;
    logic [1:0]  scsu_m_ahb_mhsize;
    logic        scsu_m_ahb_mhwrite;
    logic [15:0] scsu_m_ahb_mhaddr;
    logic [15:0] scsu_m_ahb_mhwdata;
    logic [15:0] ahb_scsu_m_shrdata;
    logic        ahb_scsu_m_shready;
    logic [1:0]  ahb_scsu_m_shresp;

    modport master (
        input  core_req, core_wr, core_size, core_addr, core_wdata,
        output core_ack, core_done, core_err, core_rdata,
        output scsu_m_ahb_mhtrans, scsu_m_ahb_mhsize, scsu_m_ahb_mhwrite,
        output scsu_m_ahb_mhaddr, scsu_m_ahb_mhwdata,
        input  ahb_scsu_m_shrdata, ahb_scsu_m_shready, ahb_scsu_m_shresp
    );

    modport slave (
        output core_req, core_wr, core_size, core_addr, core_wdata,
        input  core_ack, core_done, core_err, core_rdata,
        input  scsu_m_ahb_mhtrans, scsu_m_ahb_mhsize, scsu_m_ahb_mhwrite,
        input  scsu_m_ahb_mhaddr, scsu_m_ahb_mhwdata,
        output ahb_scsu_m_shrdata, ahb_scsu_m_shready, ahb_scsu_m_shresp
    );
endinterface

// File: rtl/ahb_master.sv
// AHB-lite master: pipelined NONSEQ singles from the core req/ack port, with wait states,
// two-cycle ERROR recovery (pending address phase re-issued) and a data-phase timeout.
module ahb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    ahb_master_if.master bus
);
    localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic        r_a_vld, r_a_ill, r_a_wr;
    logic [1:0]  r_a_size;
    logic [15:0] r_a_addr, r_a_wdata;
    logic        r_d_vld, r_d_ill, r_d_wr, r_d_half, r_d_a0;
    logic        r_abort;
    logic [CW-1:0] r_cnt;
    logic        r_done, r_err;
    logic [15:0] r_rdata, r_mhwdata;

    logic        w_rdy, w_ok, w_ack, w_acc, w_to, w_d_ret, w_err1, w_a_adv;
    logic [15:0] w_rd_val, w_wr_val;

    assign w_rdy   = bus.ahb_scsu_m_shready;
    assign w_ok    = (bus.ahb_scsu_m_shresp == 2'b00);
    assign w_ack   = !i_rst && !r_abort && (!r_a_vld || w_rdy) && !(r_d_vld && !w_rdy && r_a_vld);
    assign w_acc   = bus.core_req && w_ack;
    assign w_to    = r_d_vld && !w_rdy && (r_cnt == CNT_LAST);
    assign w_d_ret = r_d_vld && w_rdy;
    assign w_err1  = r_d_vld && !r_d_ill && !r_abort && !w_rdy && !w_ok;
    // The held transfer stays off the bus while ABORT is set and re-issues once it clears.
    assign w_a_adv = r_a_vld && !r_abort && w_rdy;

    assign w_rd_val = r_d_half ? bus.ahb_scsu_m_shrdata
                               : {8'h00, r_d_a0 ? bus.ahb_scsu_m_shrdata[15:8]
                                                : bus.ahb_scsu_m_shrdata[7:0]};
    assign w_wr_val = r_a_size[0] ? r_a_wdata : {2{r_a_wdata[7:0]}};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_vld   <= 1'b0;
            r_a_ill   <= 1'b0;
            r_a_wr    <= 1'b0;
            r_a_size  <= 2'b00;
            r_a_addr  <= 16'h0000;
            r_a_wdata <= 16'h0000;
            r_d_vld   <= 1'b0;
            r_d_ill   <= 1'b0;
            r_d_wr    <= 1'b0;
            r_d_half  <= 1'b0;
            r_d_a0    <= 1'b0;
            r_abort   <= 1'b0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 16'h0000;
            r_mhwdata <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_to) begin
                r_d_vld <= 1'b0;
                r_abort <= 1'b0;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
            end else if (w_d_ret) begin
                r_d_vld <= 1'b0;
                r_abort <= 1'b0;
                r_done  <= 1'b1;
                r_err   <= r_d_ill || r_abort || !w_ok;
                if (!r_d_ill && !r_d_wr && !r_abort && w_ok)
                    r_rdata <= w_rd_val;
            end else if (w_err1) begin
                r_abort <= 1'b1;
            end

            if (r_d_vld && !w_rdy)
                r_cnt <= r_cnt + CW'(1);

            // Illegal-size transfers ride the pipeline as an IDLE slot so they retire in order.
            if (w_a_adv) begin
                r_d_vld  <= 1'b1;
                r_d_ill  <= r_a_ill;
                r_d_wr   <= r_a_wr;
                r_d_half <= r_a_size[0];
                r_d_a0   <= r_a_addr[0];
                r_cnt    <= '0;
                if (r_a_wr && !r_a_ill)
                    r_mhwdata <= w_wr_val;
            end
            if (w_a_adv || w_to)
                r_a_vld <= 1'b0;

            if (w_acc) begin
                if (bus.core_size[1] && !r_a_vld && !r_d_vld) begin
                    r_done <= 1'b1;
                    r_err  <= 1'b1;
                end else begin
                    r_a_vld   <= 1'b1;
                    r_a_ill   <= bus.core_size[1];
                    r_a_wr    <= bus.core_wr;
                    r_a_size  <= bus.core_size;
                    r_a_addr  <= bus.core_addr;
                    r_a_wdata <= bus.core_wdata;
                end
            end
        end
    end

    assign bus.core_ack           = w_ack;
    assign bus.core_done          = r_done;
    assign bus.core_err           = r_err;
    assign bus.core_rdata         = r_rdata;
    assign bus.scsu_m_ahb_mhtrans = {r_a_vld && !r_a_ill && !r_abort, 1'b0};
    assign bus.scsu_m_ahb_mhsize  = r_a_size;
    assign bus.scsu_m_ahb_mhwrite = r_a_wr;
    assign bus.scsu_m_ahb_mhaddr  = r_a_addr;
    assign bus.scsu_m_ahb_mhwdata = r_mhwdata;
endmodule

// File: tb/tb_ahb_master.sv
// Directed cycle-by-cycle bench for ahb_master: writes, pipelined reads, wait states,
// ERROR recovery, timeout, illegal size and mid-transfer reset.
module tb_ahb_master;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ahb_master_if bus();

    ahb_master #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic wr, input logic [1:0] sz, input logic [15:0] a, input logic [15:0] d);
        bus.core_req   = 1'b1;
        bus.core_wr    = wr;
        bus.core_size  = sz;
        bus.core_addr  = a;
        bus.core_wdata = d;
        #1;
    endtask

    task automatic idle();
        bus.core_req = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.core_req = 1'b0; bus.core_wr = 1'b0; bus.core_size = 2'b00;
        bus.core_addr = 16'h0; bus.core_wdata = 16'h0;
        bus.ahb_scsu_m_shrdata = 16'h0; bus.ahb_scsu_m_shready = 1'b1; bus.ahb_scsu_m_shresp = 2'b00;

        tick(); tick(); #1;
        chk("rst_ack", bus.core_ack, 0);
        chk("rst_trans", bus.scsu_m_ahb_mhtrans, 0);
        chk("rst_done", bus.core_done, 0);
        chk("rst_err", bus.core_err, 0);
        chk("rst_rdata", bus.core_rdata, 0);
        chk("rst_addr", bus.scsu_m_ahb_mhaddr, 0);
        rst = 1'b0;

        // single halfword write, no waits
        tick(); put(1, 2'b01, 16'h0010, 16'hBEEF); chk("t1_ack", bus.core_ack, 1);
        tick(); idle();
        chk("t1_trans", bus.scsu_m_ahb_mhtrans, 2'b10);
        chk("t1_addr", bus.scsu_m_ahb_mhaddr, 16'h0010);
        chk("t1_write", bus.scsu_m_ahb_mhwrite, 1);
        chk("t1_size", bus.scsu_m_ahb_mhsize, 2'b01);
        tick(); #1;
        chk("t1_trans_idle", bus.scsu_m_ahb_mhtrans, 0);
        chk("t1_wdata", bus.scsu_m_ahb_mhwdata, 16'hBEEF);
        chk("t1_done_early", bus.core_done, 0);
        tick(); #1;
        chk("t1_done", bus.core_done, 1);
        chk("t1_err", bus.core_err, 0);
        tick(); #1; chk("t1_done_pulse", bus.core_done, 0);

        // back-to-back reads
        tick(); put(0, 2'b01, 16'h0010, 16'h0); chk("t2_ack1", bus.core_ack, 1);
        tick(); put(0, 2'b00, 16'h0011, 16'h0);
        chk("t2_trans1", bus.scsu_m_ahb_mhtrans, 2'b10);
        chk("t2_addr1", bus.scsu_m_ahb_mhaddr, 16'h0010);
        chk("t2_ack2", bus.core_ack, 1);
        tick(); bus.ahb_scsu_m_shrdata = 16'hBEEF; idle();
        chk("t2_trans2", bus.scsu_m_ahb_mhtrans, 2'b10);
        chk("t2_addr2", bus.scsu_m_ahb_mhaddr, 16'h0011);
        chk("t2_size2", bus.scsu_m_ahb_mhsize, 2'b00);
        tick(); #1;
        chk("t2_done1", bus.core_done, 1);
        chk("t2_rdata1", bus.core_rdata, 16'hBEEF);
        chk("t2_trans_idle", bus.scsu_m_ahb_mhtrans, 0);
        tick(); #1;
        chk("t2_done2", bus.core_done, 1);
        chk("t2_rdata2", bus.core_rdata, 16'h00BE);
        tick(); #1; chk("t2_done_end", bus.core_done, 0);

        // three wait states in a write data phase, read pending in A
        tick(); put(1, 2'b01, 16'h0020, 16'h1234); chk("t3_ack1", bus.core_ack, 1);
        tick(); put(0, 2'b01, 16'h0022, 16'h0); chk("t3_ack2", bus.core_ack, 1);
        tick(); bus.ahb_scsu_m_shready = 1'b0; put(1, 2'b00, 16'h0030, 16'h00A5);
        chk("t3_w1_ack", bus.core_ack, 0);
        chk("t3_w1_addr", bus.scsu_m_ahb_mhaddr, 16'h0022);
        chk("t3_w1_trans", bus.scsu_m_ahb_mhtrans, 2'b10);
        chk("t3_w1_wdata", bus.scsu_m_ahb_mhwdata, 16'h1234);
        tick(); #1;
        chk("t3_w2_ack", bus.core_ack, 0);
        chk("t3_w2_addr", bus.scsu_m_ahb_mhaddr, 16'h0022);
        chk("t3_w2_done", bus.core_done, 0);
        tick(); #1;
        chk("t3_w3_ack", bus.core_ack, 0);
        chk("t3_w3_trans", bus.scsu_m_ahb_mhtrans, 2'b10);
        tick(); bus.ahb_scsu_m_shready = 1'b1; #1;
        chk("t3_rel_ack", bus.core_ack, 1);
        tick(); bus.ahb_scsu_m_shrdata = 16'h5678; idle();
        chk("t3_done_w", bus.core_done, 1);
        chk("t3_err_w", bus.core_err, 0);
        chk("t3_trans3", bus.scsu_m_ahb_mhtrans, 2'b10);
        chk("t3_addr3", bus.scsu_m_ahb_mhaddr, 16'h0030);
        chk("t3_size3", bus.scsu_m_ahb_mhsize, 2'b00);
        tick(); #1;
        chk("t3_done_r", bus.core_done, 1);
        chk("t3_rdata", bus.core_rdata, 16'h5678);
        chk("t3_wdata_byte", bus.scsu_m_ahb_mhwdata, 16'hA5A5);
        tick(); #1;
        chk("t3_done_w3", bus.core_done, 1);
        chk("t3_err_w3", bus.core_err, 0);
        tick(); #1; chk("t3_done_end", bus.core_done, 0);

        // two-cycle ERROR on a write with a read pending in A
        tick(); put(1, 2'b01, 16'h0040, 16'hCAFE); chk("t4_ack1", bus.core_ack, 1);
        tick(); put(0, 2'b01, 16'h0042, 16'h0); chk("t4_ack2", bus.core_ack, 1);
        tick(); bus.ahb_scsu_m_shready = 1'b0; bus.ahb_scsu_m_shresp = 2'b01; idle();
        chk("t4_e1_trans", bus.scsu_m_ahb_mhtrans, 2'b10);
        chk("t4_e1_addr", bus.scsu_m_ahb_mhaddr, 16'h0042);
        chk("t4_e1_wdata", bus.scsu_m_ahb_mhwdata, 16'hCAFE);
        tick(); bus.ahb_scsu_m_shready = 1'b1; #1;
        chk("t4_e2_trans", bus.scsu_m_ahb_mhtrans, 0);
        chk("t4_e2_done", bus.core_done, 0);
        chk("t4_e2_ack", bus.core_ack, 0);
        tick(); bus.ahb_scsu_m_shresp = 2'b00; #1;
        chk("t4_done_w", bus.core_done, 1);
        chk("t4_err_w", bus.core_err, 1);
        chk("t4_reissue", bus.scsu_m_ahb_mhtrans, 2'b10);
        chk("t4_reissue_addr", bus.scsu_m_ahb_mhaddr, 16'h0042);
        tick(); bus.ahb_scsu_m_shrdata = 16'h1357; #1;
        chk("t4_gap_done", bus.core_done, 0);
        tick(); #1;
        chk("t4_done_r", bus.core_done, 1);
        chk("t4_err_r", bus.core_err, 0);
        chk("t4_rdata", bus.core_rdata, 16'h1357);

        // data-phase timeout after 16 wait cycles
        tick(); put(1, 2'b01, 16'h0050, 16'h0F0F); chk("t5_ack", bus.core_ack, 1);
        tick(); idle(); chk("t5_trans", bus.scsu_m_ahb_mhtrans, 2'b10);
        for (int i = 0; i < 16; i++) begin
            tick(); bus.ahb_scsu_m_shready = 1'b0; #1;
            chk("t5_wait_done", bus.core_done, 0);
        end
        tick(); bus.ahb_scsu_m_shready = 1'b1; #1;
        chk("t5_to_done", bus.core_done, 1);
        chk("t5_to_err", bus.core_err, 1);
        chk("t5_to_trans", bus.scsu_m_ahb_mhtrans, 0);
        tick(); #1; chk("t5_late_rdy", bus.core_done, 0);
        tick(); put(0, 2'b01, 16'h0010, 16'h0); chk("t5_new_ack", bus.core_ack, 1);
        tick(); idle(); chk("t5_new_trans", bus.scsu_m_ahb_mhtrans, 2'b10);
        tick(); bus.ahb_scsu_m_shrdata = 16'h2468; #1;
        tick(); #1;
        chk("t5_new_done", bus.core_done, 1);
        chk("t5_new_err", bus.core_err, 0);
        chk("t5_new_rdata", bus.core_rdata, 16'h2468);

        // illegal size while idle: immediate done+err, no bus cycle
        tick(); put(0, 2'b10, 16'h0060, 16'h0); chk("t6_ill_ack", bus.core_ack, 1);
        tick(); idle();
        chk("t6_ill_done", bus.core_done, 1);
        chk("t6_ill_err", bus.core_err, 1);
        chk("t6_ill_trans", bus.scsu_m_ahb_mhtrans, 0);
        tick(); #1;
        chk("t6_ill_done_end", bus.core_done, 0);
        chk("t6_ill_trans_end", bus.scsu_m_ahb_mhtrans, 0);

        // illegal size behind a write: completion deferred, order kept
        tick(); put(1, 2'b01, 16'h0080, 16'h1111); chk("t6_d_ack1", bus.core_ack, 1);
        tick(); put(0, 2'b11, 16'h0081, 16'h0); chk("t6_d_ack2", bus.core_ack, 1);
        tick(); idle();
        chk("t6_d_trans", bus.scsu_m_ahb_mhtrans, 0);
        chk("t6_d_early", bus.core_done, 0);
        tick(); #1;
        chk("t6_d_done_w", bus.core_done, 1);
        chk("t6_d_err_w", bus.core_err, 0);
        tick(); #1;
        chk("t6_d_done_ill", bus.core_done, 1);
        chk("t6_d_err_ill", bus.core_err, 1);
        tick(); #1; chk("t6_d_end", bus.core_done, 0);

        // reset in the middle of a read data phase
        tick(); put(0, 2'b01, 16'h0070, 16'h0); chk("t6_r_ack", bus.core_ack, 1);
        tick(); idle(); chk("t6_r_trans", bus.scsu_m_ahb_mhtrans, 2'b10);
        tick(); bus.ahb_scsu_m_shready = 1'b0; rst = 1'b1; #1;
        chk("t6_rst_ack", bus.core_ack, 0);
        tick(); rst = 1'b0; bus.ahb_scsu_m_shready = 1'b1; #1;
        chk("t6_rst_trans", bus.scsu_m_ahb_mhtrans, 0);
        chk("t6_rst_addr", bus.scsu_m_ahb_mhaddr, 0);
        chk("t6_rst_size", bus.scsu_m_ahb_mhsize, 0);
        chk("t6_rst_write", bus.scsu_m_ahb_mhwrite, 0);
        chk("t6_rst_wdata", bus.scsu_m_ahb_mhwdata, 0);
        chk("t6_rst_done", bus.core_done, 0);
        chk("t6_rst_err", bus.core_err, 0);
        chk("t6_rst_rdata", bus.core_rdata, 0);
        tick(); #1; chk("t6_post_done1", bus.core_done, 0);
        tick(); #1; chk("t6_post_done2", bus.core_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
